// File: rtl/p_mem.sv
// p_mem: memory-access pipeline stage.
// Runs loads and stores from EX as little-endian sequences of byte transfers
// over a byte-wide req/ack port. While the access is in progress, busy_out
// stalls the upstream stages. Non-memory instructions pass straight through
// with no added latency.
//
// State table:
//   state | meaning
//   IDLE  | no access in progress; non-mem ops pass through
//   BUSY  | byte transfers outstanding; mem_req held until the last ack
//   DONE  | one-cycle write-back of load data (or a bubble for stores)
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   in_we, in_w_addr, in_w_data, in_opcode, in_mem_addr : EX stage result
//   mem_rdata, mem_ack                                  : memory response
//   mem_req, mem_wr, mem_a, mem_wdata                   : memory request (registered)
//   out_we, out_w_addr, out_w_data                      : to MEM/WB
//   busy_out                                            : upstream stall
module p_mem #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              in_we,
    input  logic [31:0]       in_w_addr,
    input  logic [31:0]       in_w_data,
    input  logic [4:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_wdata,
    output logic              out_we,
    output logic [31:0]       out_w_addr,
    output logic [31:0]       out_w_data,
    output logic              busy_out
);

    localparam logic [4:0] INS_EMP = 5'd0;
    localparam logic [4:0] INS_LB  = 5'd8;
    localparam logic [4:0] INS_LBU = 5'd9;
    localparam logic [4:0] INS_LH  = 5'd10;
    localparam logic [4:0] INS_LHU = 5'd11;
    localparam logic [4:0] INS_LW  = 5'd12;
    localparam logic [4:0] INS_SB  = 5'd13;
    localparam logic [4:0] INS_SH  = 5'd14;
    localparam logic [4:0] INS_SW  = 5'd15;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q,     state_d;
    logic [1:0]        cnt_q,       cnt_d;
    logic [31:0]       buf_q,       buf_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0] mem_a_q,     mem_a_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic       is_load;
    logic       is_store;
    logic [1:0] last_idx;
    logic [1:0] cnt_nxt;
    logic [7:0] store_byte_nxt;

    // Opcode decode: access kind and index of the final byte.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        last_idx = 2'd0;
        case (in_opcode)
            INS_LB, INS_LBU: is_load = 1'b1;
            INS_LH, INS_LHU: begin is_load = 1'b1; last_idx = 2'd1; end
            INS_LW:          begin is_load = 1'b1; last_idx = 2'd3; end
            INS_SB:          is_store = 1'b1;
            INS_SH:          begin is_store = 1'b1; last_idx = 2'd1; end
            INS_SW:          begin is_store = 1'b1; last_idx = 2'd3; end
            default: ;
        endcase
    end

    assign cnt_nxt = cnt_q + 2'd1;

    always_comb begin
        case (cnt_nxt)
            2'd0:    store_byte_nxt = in_w_data[7:0];
            2'd1:    store_byte_nxt = in_w_data[15:8];
            2'd2:    store_byte_nxt = in_w_data[23:16];
            default: store_byte_nxt = in_w_data[31:24];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_a_d     = mem_a_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    state_d     = BUSY;
                    cnt_d       = 2'd0;
                    buf_d       = 32'd0;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = is_store;
                    mem_a_d     = in_mem_addr;
                    mem_wdata_d = in_w_data[7:0];
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (is_load) begin
                        case (cnt_q)
                            2'd0:    buf_d[7:0]   = mem_rdata;
                            2'd1:    buf_d[15:8]  = mem_rdata;
                            2'd2:    buf_d[23:16] = mem_rdata;
                            default: buf_d[31:24] = mem_rdata;
                        endcase
                    end
                    if (cnt_q != last_idx) begin
                        cnt_d       = cnt_nxt;
                        mem_a_d     = mem_a_q + ADDR_ONE;
                        mem_wdata_d = store_byte_nxt;
                    end else begin
                        mem_req_d = 1'b0;
                        mem_wr_d  = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            buf_q       <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_a_q     <= mem_a_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_a     = mem_a_q;
    assign mem_wdata = mem_wdata_q;

    // Write-back side: passthrough in IDLE, extended load data in DONE.
    always_comb begin
        out_we     = 1'b0;
        out_w_addr = 32'd0;
        out_w_data = 32'd0;
        busy_out   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    busy_out = 1'b1;
                end else if (in_opcode != INS_EMP) begin
                    out_we     = in_we;
                    out_w_addr = in_w_addr;
                    out_w_data = in_w_data;
                end
            end
            BUSY: busy_out = 1'b1;
            default: begin
                out_w_addr = in_w_addr;
                if (is_load) begin
                    out_we = in_we;
                    case (in_opcode)
                        INS_LB:  out_w_data = {{24{buf_q[7]}}, buf_q[7:0]};
                        INS_LBU: out_w_data = {24'd0, buf_q[7:0]};
                        INS_LH:  out_w_data = {{16{buf_q[15]}}, buf_q[15:0]};
                        INS_LHU: out_w_data = {16'd0, buf_q[15:0]};
                        default: out_w_data = buf_q;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_p_mem.sv
// Scoreboard bench for p_mem: the driver pushes expected write-back results
// and expected byte requests; the memory responder and the write-back monitor
// pop and compare independently.
module tb_p_mem;

    localparam logic [4:0] INS_EMP = 5'd0;
    localparam logic [4:0] INS_ADD = 5'd1;
    localparam logic [4:0] INS_LB  = 5'd8;
    localparam logic [4:0] INS_LBU = 5'd9;
    localparam logic [4:0] INS_LH  = 5'd10;
    localparam logic [4:0] INS_LHU = 5'd11;
    localparam logic [4:0] INS_LW  = 5'd12;
    localparam logic [4:0] INS_SH  = 5'd14;
    localparam logic [4:0] INS_SW  = 5'd15;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        in_we = 1'b0;
    logic [31:0] in_w_addr = 32'd0;
    logic [31:0] in_w_data = 32'd0;
    logic [4:0]  in_opcode = INS_EMP;
    logic [31:0] in_mem_addr = 32'd0;
    logic [7:0]  mem_rdata = 8'h5A;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_wdata;
    logic        out_we;
    logic [31:0] out_w_addr, out_w_data;
    logic        busy_out;

    p_mem #(.ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .in_we(in_we), .in_w_addr(in_w_addr), .in_w_data(in_w_data),
        .in_opcode(in_opcode), .in_mem_addr(in_mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_a(mem_a), .mem_wdata(mem_wdata),
        .out_we(out_we), .out_w_addr(out_w_addr), .out_w_data(out_w_data),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} wb_t;
    typedef struct {logic [31:0] a; logic wr; logic [7:0] wd;} mreq_t;

    wb_t   wb_q[$];
    mreq_t mq[$];
    int    checks = 0;
    int    failures = 0;
    int    ack_delay = 0;
    int    ack_count = 0;
    logic [7:0] mem [0:4095];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks each byte after ack_delay wait cycles.
    int         wcnt = 0;
    logic [31:0] hold_a;
    logic        hold_wr;
    logic [7:0]  hold_wd;
    always @(negedge clk_in) begin
        if (!rst_in || !mem_req) begin
            mem_ack   = 1'b0;
            mem_rdata = 8'h5A;
            wcnt      = 0;
        end else begin
            if (wcnt == 0) begin
                hold_a  = mem_a;
                hold_wr = mem_wr;
                hold_wd = mem_wdata;
            end else begin
                chk("hold_mem_a", mem_a, hold_a);
                chk("hold_mem_wr", {31'd0, mem_wr}, {31'd0, hold_wr});
                chk("hold_mem_wdata", {24'd0, mem_wdata}, {24'd0, hold_wd});
            end
            if (wcnt >= ack_delay) begin
                mreq_t e;
                mem_ack = 1'b1;
                if (mq.size() == 0) begin
                    chk("unexpected_req", mem_a, 32'hFFFF_FFFF);
                end else begin
                    e = mq.pop_front();
                    chk("mem_a", mem_a, e.a);
                    chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
                    if (e.wr) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wd});
                end
                if (mem_wr) mem[mem_a[11:0]] = mem_wdata;
                else        mem_rdata = mem[mem_a[11:0]];
                ack_count++;
                wcnt = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'hA5;
                wcnt++;
            end
        end
    end

    // Write-back monitor: a non-bubble instruction completes when busy_out=0.
    always @(negedge clk_in) begin
        if (rst_in && in_opcode != INS_EMP && !busy_out) begin
            wb_t e;
            if (wb_q.size() == 0) begin
                chk("unexpected_wb", out_w_data, 32'hFFFF_FFFF);
            end else begin
                e = wb_q.pop_front();
                chk("out_we", {31'd0, out_we}, {31'd0, e.we});
                chk("out_w_addr", out_w_addr, e.addr);
                chk("out_w_data", out_w_data, e.data);
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic we, input logic [31:0] waddr,
                         input logic [31:0] wdata, input logic [31:0] maddr,
                         input int nbytes, input logic is_st,
                         input logic exp_we, input logic [31:0] exp_data,
                         input int exp_busy);
        wb_t w;
        int  n;
        w.we = exp_we; w.addr = waddr; w.data = exp_data;
        wb_q.push_back(w);
        for (int k = 0; k < nbytes; k++) begin
            mreq_t m;
            m.a  = maddr + 32'(k);
            m.wr = is_st;
            m.wd = is_st ? wdata[8*k +: 8] : 8'h00;
            mq.push_back(m);
        end
        @(posedge clk_in); #1;
        in_opcode = op; in_we = we; in_w_addr = waddr;
        in_w_data = wdata; in_mem_addr = maddr;
        n = 0;
        forever begin
            @(negedge clk_in);
            if (!busy_out) break;
            n++;
            if (n > 200) begin
                chk("busy_timeout", 32'(n), 32'(exp_busy));
                break;
            end
        end
        chk("busy_cycles", 32'(n), 32'(exp_busy));
        @(posedge clk_in); #1;
        in_opcode = INS_EMP; in_we = 1'b0;
    endtask

    initial begin
        int base;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
        mem[12'h110] = 8'h78; mem[12'h111] = 8'h56; mem[12'h112] = 8'h34; mem[12'h113] = 8'h12;
        mem[12'h080] = 8'h80;
        mem[12'h040] = 8'h34; mem[12'h041] = 8'hF2;
        mem[12'hFFF] = 8'h11; mem[12'h000] = 8'h22;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        #2 rst_in = 1'b1;

        // EMP with in_we set must produce a zero write-back
        @(posedge clk_in); #1;
        in_opcode = INS_EMP; in_we = 1'b1; in_w_addr = 32'd9; in_w_data = 32'h1234;
        @(negedge clk_in);
        chk("emp_we", {31'd0, out_we}, 32'd0);
        chk("emp_addr", out_w_addr, 32'd0);
        chk("emp_data", out_w_data, 32'd0);
        chk("emp_busy", {31'd0, busy_out}, 32'd0);
        in_we = 1'b0;

        ack_delay = 0;
        issue(INS_LW,  1'b1, 32'd5,  32'd0, 32'h100, 4, 1'b0, 1'b1, 32'h12345678, 5);
        issue(INS_LB,  1'b1, 32'd6,  32'd0, 32'h080, 1, 1'b0, 1'b1, 32'hFFFFFF80, 2);
        issue(INS_LBU, 1'b1, 32'd6,  32'd0, 32'h080, 1, 1'b0, 1'b1, 32'h00000080, 2);
        issue(INS_LH,  1'b1, 32'd7,  32'd0, 32'h040, 2, 1'b0, 1'b1, 32'hFFFFF234, 3);
        issue(INS_LHU, 1'b1, 32'd7,  32'd0, 32'h040, 2, 1'b0, 1'b1, 32'h0000F234, 3);
        // Address wrap at the top of the address space
        issue(INS_LHU, 1'b1, 32'd8,  32'd0, 32'hFFFFFFFF, 2, 1'b0, 1'b1, 32'h00002211, 3);
        issue(INS_SH,  1'b1, 32'd10, 32'h0000BEEF, 32'h202, 2, 1'b1, 1'b0, 32'd0, 3);
        chk("sh_mem202", {24'd0, mem[12'h202]}, 32'hEF);
        chk("sh_mem203", {24'd0, mem[12'h203]}, 32'hBE);
        issue(INS_ADD, 1'b1, 32'd3,  32'd5, 32'd0, 0, 1'b0, 1'b1, 32'd5, 0);
        issue(5'h1F,   1'b1, 32'd11, 32'hDEADBEEF, 32'd0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 0);
        issue(INS_ADD, 1'b0, 32'd12, 32'h77, 32'd0, 0, 1'b0, 1'b0, 32'h77, 0);

        ack_delay = 3;
        issue(INS_LW,  1'b1, 32'd13, 32'd0, 32'h110, 4, 1'b0, 1'b1, 32'h12345678, 17);

        // Reset in the middle of a store, while byte 2 is outstanding
        ack_delay = 2;
        base = ack_count;
        for (int k = 0; k < 4; k++) begin
            mreq_t m;
            m.a = 32'h300 + 32'(k); m.wr = 1'b1;
            m.wd = (k == 0) ? 8'hD4 : (k == 1) ? 8'hC3 : (k == 2) ? 8'hB2 : 8'hA1;
            mq.push_back(m);
        end
        @(posedge clk_in); #1;
        in_opcode = INS_SW; in_we = 1'b0; in_w_addr = 32'd14;
        in_w_data = 32'hA1B2C3D4; in_mem_addr = 32'h300;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk_in); #1;
            if (ack_count >= base + 2) break;
        end
        chk("sw_acks_before_rst", 32'(ack_count - base), 32'd2);
        #1 rst_in = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_mem_a", mem_a, 32'd0);
        in_opcode = INS_EMP;
        mq.delete();
        @(negedge clk_in); #2 rst_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_busy", {31'd0, busy_out}, 32'd0);
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        chk("sw_mem300", {24'd0, mem[12'h300]}, 32'hD4);
        chk("sw_mem301", {24'd0, mem[12'h301]}, 32'hC3);
        chk("sw_mem302", {24'd0, mem[12'h302]}, 32'h00);
        repeat (3) @(negedge clk_in);
        chk("post_rst_idle_req", {31'd0, mem_req}, 32'd0);

        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
